// File: rtl/vtree_filler.sv
`default_nettype none
// ============================================================================
// Module      : vtree_filler
// Description : Round-robin feeder for the virtual merge sorter tree. Picks at
//               most one eligible way per cycle and forwards that way's record
//               bundle, registered, to the tree's din/dinen/din_idx interface.
//               ARB_MODE=0 is the legacy fixed rotation; ARB_MODE=1 is a
//               work-conserving round robin. Each way can be held off for HOLD
//               cycles after a grant, and tree_stall blocks all grants.
// Ports       : CLK, RST     - clock, synchronous active-high reset
//               src_dat      - all ways' bundles, way i at slice i
//               src_vld      - per-way bundle ready
//               src_rdy      - one-hot grant, same cycle (consumes bundle)
//               tree_emp     - per-way empty/refill request from the tree
//               tree_stall   - blocks all grants this cycle
//               dot/doten    - registered bundle and its valid
//               dot_idx      - way index of dot
//               issue_cnt    - total bundles issued (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module vtree_filler #(
    parameter int W_LOG    = 5,
    parameter int P_LOG    = 3,
    parameter int DATW     = 64,
    parameter int ARB_MODE = 1,
    parameter int HOLD     = 2,
    parameter int CNTW     = 32
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [(DATW<<(W_LOG+P_LOG))-1:0]  src_dat,
    input  logic [(1<<W_LOG)-1:0]             src_vld,
    output logic [(1<<W_LOG)-1:0]             src_rdy,
    input  logic [(1<<W_LOG)-1:0]             tree_emp,
    input  logic                              tree_stall,
    output logic [(DATW<<P_LOG)-1:0]          dot,
    output logic                              doten,
    output logic [W_LOG-1:0]                  dot_idx,
    output logic [CNTW-1:0]                   issue_cnt
);

    localparam int WAYS  = 1 << W_LOG;
    localparam int BUNW  = DATW << P_LOG;
    // Hold-off counter must be able to hold HOLD; keep at least one bit.
    localparam int HOLDW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

    logic [W_LOG-1:0] r_ptr;
    logic [HOLDW-1:0] r_holdoff [WAYS];

    logic [WAYS-1:0]  w_req;
    logic             w_gnt_any;
    logic [W_LOG-1:0] w_gnt_idx;
    logic [W_LOG-1:0] w_ptr_nxt;
    logic [BUNW-1:0]  w_gnt_dat;

    // Eligibility; reset and stall suppress every request so src_rdy is
    // guaranteed low in those cycles.
    generate
        for (genvar i = 0; i < WAYS; i++) begin : g_req
            assign w_req[i] = src_vld[i] & tree_emp[i] & (r_holdoff[i] == '0)
                              & ~tree_stall & ~RST;
        end
    endgenerate

    generate
        if (ARB_MODE == 0) begin : g_arb_fixed
            // Legacy: the pointer rotates every cycle whether or not the
            // pointed-to way can take the slot.
            assign w_gnt_any = w_req[r_ptr];
            assign w_gnt_idx = r_ptr;
            assign w_ptr_nxt = r_ptr + W_LOG'(1);
        end else begin : g_arb_rr
            // First requester at or after the pointer, cyclically. The sum
            // is W_LOG bits wide so the search wraps naturally.
            always_comb begin
                w_gnt_any = 1'b0;
                w_gnt_idx = r_ptr;
                for (int k = 0; k < WAYS; k++) begin
                    if (!w_gnt_any && w_req[r_ptr + W_LOG'(k)]) begin
                        w_gnt_any = 1'b1;
                        w_gnt_idx = r_ptr + W_LOG'(k);
                    end
                end
            end
            // Advance past the winner so it becomes lowest priority.
            assign w_ptr_nxt = w_gnt_any ? (w_gnt_idx + W_LOG'(1)) : r_ptr;
        end
    endgenerate

    assign src_rdy = w_gnt_any ? (WAYS'(1) << w_gnt_idx) : '0;

    always_comb begin
        w_gnt_dat = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (w_gnt_idx == W_LOG'(i)) begin
                w_gnt_dat = src_dat[i*BUNW +: BUNW];
            end
        end
    end

    // Hold-off keeps a just-filled way out until the tree's emp flag has had
    // time to drop, so the same way is not filled twice.
    generate
        for (genvar i = 0; i < WAYS; i++) begin : g_hold
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_holdoff[i] <= '0;
                end else if (src_rdy[i]) begin
                    r_holdoff[i] <= HOLDW'(HOLD);
                end else if (r_holdoff[i] != '0) begin
                    r_holdoff[i] <= r_holdoff[i] - HOLDW'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr     <= '0;
            doten     <= 1'b0;
            dot       <= '0;
            dot_idx   <= '0;
            issue_cnt <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
            doten <= w_gnt_any;
            if (w_gnt_any) begin
                dot       <= w_gnt_dat;
                dot_idx   <= w_gnt_idx;
                issue_cnt <= issue_cnt + CNTW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vtree_filler.sv
`default_nettype none
// ============================================================================
// Module      : tb_vtree_filler
// Description : Directed bench for vtree_filler (W_LOG=2, P_LOG=1, DATW=8,
//               HOLD=2). One instance in round-robin mode, one in fixed
//               rotation mode, sharing clock, reset and source data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vtree_filler;

    localparam int W_LOG = 2;
    localparam int P_LOG = 1;
    localparam int DATW  = 8;
    localparam int HOLD  = 2;
    localparam int CNTW  = 32;

    logic        CLK = 1'b0;
    logic        RST;
    logic [63:0] src_dat;

    logic [3:0]  vld1, emp1, rdy1;
    logic        stall1;
    logic [15:0] dot1;
    logic        doten1;
    logic [1:0]  idx1;
    logic [31:0] cnt1;

    logic [3:0]  vld0, emp0, rdy0;
    logic        stall0;
    logic [15:0] dot0;
    logic        doten0;
    logic [1:0]  idx0;
    logic [31:0] cnt0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    vtree_filler #(
        .W_LOG(W_LOG), .P_LOG(P_LOG), .DATW(DATW),
        .ARB_MODE(1), .HOLD(HOLD), .CNTW(CNTW)
    ) u_rr (
        .CLK(CLK), .RST(RST), .src_dat(src_dat), .src_vld(vld1),
        .src_rdy(rdy1), .tree_emp(emp1), .tree_stall(stall1),
        .dot(dot1), .doten(doten1), .dot_idx(idx1), .issue_cnt(cnt1)
    );

    vtree_filler #(
        .W_LOG(W_LOG), .P_LOG(P_LOG), .DATW(DATW),
        .ARB_MODE(0), .HOLD(HOLD), .CNTW(CNTW)
    ) u_fix (
        .CLK(CLK), .RST(RST), .src_dat(src_dat), .src_vld(vld0),
        .src_rdy(rdy0), .tree_emp(emp0), .tree_stall(stall0),
        .dot(dot0), .doten(doten0), .dot_idx(idx0), .issue_cnt(cnt0)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] slice(input int i);
        return {8'(10*i + 1), 8'(10*i)};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Leaves the bench at posedge+1 with RST low: the next cycle is cycle 0.
    task automatic do_reset();
        RST = 1'b1;
        vld1 = '0; emp1 = '0; stall1 = 1'b0;
        vld0 = '0; emp0 = '0; stall0 = 1'b0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_rdy;
        logic       exp_g;
        int         exp_w;
        logic [3:0] stall_rdy [6];

        for (int i = 0; i < 4; i++) src_dat[i*16 +: 16] = slice(i);

        // ---- reset state and round-robin over all ways ----
        RST = 1'b1;
        vld1 = 4'b1111; emp1 = 4'b1111; stall1 = 1'b0;
        vld0 = '0; emp0 = '0; stall0 = 1'b0;
        tick();
        tick();
        check("rst_rdy", rdy1, 4'b0000);
        check("rst_doten", doten1, 0);
        check("rst_dot", dot1, 0);
        check("rst_idx", idx1, 0);
        check("rst_cnt", cnt1, 0);
        check("rst_fix_doten", doten0, 0);
        RST = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("rr_rdy%0d", k), rdy1, 4'b0001 << (k % 4));
            tick();
            check($sformatf("rr_doten%0d", k), doten1, 1);
            check($sformatf("rr_idx%0d", k), idx1, k % 4);
            check($sformatf("rr_dot%0d", k), dot1, slice(k % 4));
            check($sformatf("rr_cnt%0d", k), cnt1, k + 1);
        end

        // ---- single eligible way with hold-off ----
        do_reset();
        vld1 = 4'b0100; emp1 = 4'b1111;
        for (int k = 0; k < 7; k++) begin
            exp_g = (k % 3 == 0);
            #1;
            check($sformatf("hold_rdy%0d", k), rdy1, exp_g ? 4'b0100 : 4'b0000);
            tick();
            check($sformatf("hold_doten%0d", k), doten1, exp_g);
            if (exp_g) check($sformatf("hold_dot%0d", k), dot1, slice(2));
        end

        // ---- fixed rotation: way 2 only when ptr==2 ----
        do_reset();
        vld0 = 4'b0100; emp0 = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            exp_g = (k % 4 == 2);
            #1;
            check($sformatf("fix_rdy%0d", k), rdy0, exp_g ? 4'b0100 : 4'b0000);
            tick();
            check($sformatf("fix_doten%0d", k), doten0, exp_g);
        end
        vld0 = '0;

        // ---- stall in cycles 3-4, then way 3 ----
        do_reset();
        vld1 = 4'b1111; emp1 = 4'b1111;
        stall_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b1000};
        for (int k = 0; k < 6; k++) begin
            stall1 = (k == 3 || k == 4);
            exp_rdy = stall_rdy[k];
            #1;
            check($sformatf("stall_rdy%0d", k), rdy1, exp_rdy);
            tick();
            check($sformatf("stall_doten%0d", k), doten1, exp_rdy != 0);
            if (exp_rdy != 0) begin
                exp_w = $clog2(int'(exp_rdy));
                check($sformatf("stall_idx%0d", k), idx1, exp_w);
                check($sformatf("stall_dot%0d", k), dot1, slice(exp_w));
            end
        end
        stall1 = 1'b0;
        check("way3_dot", dot1, 16'h1F1E);
        check("way3_idx", idx1, 3);
        check("way3_cnt", cnt1, 4);

        // ---- no further grant: data path holds ----
        vld1 = '0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("holdq_doten%0d", k), doten1, 0);
            check($sformatf("holdq_dot%0d", k), dot1, 16'h1F1E);
            check($sformatf("holdq_idx%0d", k), idx1, 3);
        end

        // ---- reset in the middle of granting ----
        do_reset();
        vld1 = 4'b1111; emp1 = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            #1;
            check($sformatf("mid_rdy%0d", k), rdy1, 4'b0001 << k);
            tick();
        end
        RST = 1'b1;
        #1;
        check("mid_rst_rdy", rdy1, 4'b0000);
        tick();
        check("mid_rst_doten", doten1, 0);
        check("mid_rst_cnt", cnt1, 0);
        RST = 1'b0;
        #1;
        check("post_rst_rdy", rdy1, 4'b0001);
        tick();
        check("post_rst_doten", doten1, 1);
        check("post_rst_idx", idx1, 0);
        check("post_rst_cnt", cnt1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
